// File: rtl/key_event_timestamper.sv
// key_event_timestamper: microsecond timebase, KEY debounce, and timestamped event FIFO
module key_event_timestamper #(
  parameter int CLK_PER_US  = 50,
  parameter int DEBOUNCE_US = 5000,
  parameter int NKEYS       = 4,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic [3:0]  KEY,
  output logic [31:0] microseconds,
  output logic        ev_valid,
  output logic [34:0] ev_data,
  input  logic        ev_pop,
  output logic [4:0]  ev_count,
  output logic        overflow,
  input  logic        ovf_clear
);
  localparam int PW = $clog2(CLK_PER_US);
  localparam int DW = (DEBOUNCE_US > 1) ? $clog2(DEBOUNCE_US) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_PER_US - 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_US - 1);
  localparam logic [CW-1:0] DEPTH   = CW'(FIFO_DEPTH);

  logic [PW-1:0]    r_pre;
  logic [31:0]      r_us;
  logic [NKEYS-1:0] r_s1, r_s2, r_stable, r_pend;
  logic [DW-1:0]    r_cnt [NKEYS];
  logic [31:0]      r_ts  [NKEYS];
  logic             r_wr_en;
  logic [34:0]      r_wr_data;
  logic [34:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic             w_tick, w_pop, w_wr, w_drop;
  logic [NKEYS-1:0] w_commit, w_grant;
  logic [1:0]       w_sel;

  assign w_tick       = (r_pre == PRE_MAX);
  assign microseconds = r_us;
  assign w_pop        = ev_pop & (r_count != '0);
  assign w_wr         = r_wr_en & ((r_count < DEPTH) | w_pop);
  assign w_drop       = r_wr_en & ~w_wr;
  assign ev_valid     = (r_count != '0);
  assign ev_data      = ev_valid ? r_mem[r_rp] : '0;
  assign ev_count     = 5'(r_count);
  assign overflow     = r_ovf;

  // Prescaler produces one tick per microsecond; the microsecond count advances on it
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_pre <= '0;
      r_us  <= '0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (w_tick) r_us <= r_us + 1'b1;
    end
  end

  // Two-flop synchroniser, inverted at the input so 1 means pressed and reset means released
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= ~KEY[NKEYS-1:0];
      r_s2 <= r_s1;
    end
  end

  // A key commits on the tick that completes DEBOUNCE_US ticks away from its stable level
  always_comb begin
    w_commit = '0;
    for (int k = 0; k < NKEYS; k++)
      w_commit[k] = w_tick & (r_s2[k] != r_stable[k]) & (r_cnt[k] == DEB_MAX);
  end

  // Per-key debounce counters, committed level and commit timestamp
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_stable <= '0;
      for (int k = 0; k < NKEYS; k++) begin
        r_cnt[k] <= '0;
        r_ts[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NKEYS; k++) begin
        if (r_s2[k] == r_stable[k]) r_cnt[k] <= '0;
        else if (w_commit[k]) begin
          r_stable[k] <= r_s2[k];
          r_cnt[k]    <= '0;
          r_ts[k]     <= r_us;
        end else if (w_tick) r_cnt[k] <= r_cnt[k] + 1'b1;
      end
    end
  end

  // Fixed-priority grant: lowest-index pending key wins
  always_comb begin
    w_grant = '0;
    w_sel   = '0;
    for (int k = NKEYS - 1; k >= 0; k--)
      if (r_pend[k]) begin
        w_grant    = '0;
        w_grant[k] = 1'b1;
        w_sel      = 2'(k);
      end
  end

  // Pending bits drain one per cycle into a registered write request
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_pend    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_data <= '0;
    end else begin
      r_pend    <= (r_pend & ~w_grant) | w_commit;
      r_wr_en   <= |r_pend;
      r_wr_data <= {r_stable[w_sel], w_sel, r_ts[w_sel]};
    end
  end

  // FIFO storage needs no reset: the head is gated by ev_valid
  always_ff @(posedge CLOCK_50) begin
    if (w_wr) r_mem[r_wp] <= r_wr_data;
  end

  // FIFO pointers, occupancy and sticky overflow (a drop beats a clear)
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr)  r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_count <= r_count + CW'(w_wr) - CW'(w_pop);
      r_ovf   <= w_drop | (r_ovf & ~ovf_clear);
    end
  end
endmodule
